// File: rtl/inta_sequencer.sv
// Purpose  : CPU side of the 8259A interrupt path. Keeps the ISR under fully-nested
//            priority, drives INT, runs the two-pulse 8086 INTA acknowledge and places
//            the vector byte on the data bus. Also applies EOI commands.
// Latency  : int_o one cycle after a request qualifies; ISR/irr_clr one cycle after
//            the first INTA falls; vector enabled one cycle after the second INTA falls.
// Backpressure: none. The CPU paces the acknowledge via inta_n. A missing second INTA
//            is abandoned after INTA_TIMEOUT cycles.
//
// Build option: define AUTO_EOI_EN for Automatic EOI mode. In this mode, the ISR bit of
//            the acknowledged level clears at the second INTA rising edge. Spurious
//            acknowledges are unaffected, and explicit EOIs are still honoured.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   irr                 masked Interrupt Request Register
//   resolved_interrupt  highest-priority requesting level from the priority resolver
//   icw2_base           vector bits T7..T3
//   inta_n              CPU acknowledge, active low, synchronous to clk
//   eoi_valid           one-cycle EOI strobe
//   eoi_specific        1 = specific EOI (eoi_level), 0 = non-specific
//   eoi_level           level cleared by a specific EOI
//   int_o               interrupt request to the CPU
//   isr                 In-Service Register
//   irr_clr             one-cycle one-hot IRR clear at the first INTA
//   data_out, data_oe   vector byte and its bus drive enable
//   spurious            one-cycle pulse when a level-7 spurious vector completes
module inta_sequencer #(
    parameter int INTA_TIMEOUT = 16,
    parameter int TO_W         = 5      // 2**TO_W must exceed INTA_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irr,
    input  logic [2:0] resolved_interrupt,
    input  logic [4:0] icw2_base,
    input  logic       inta_n,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_o,
    output logic [7:0] isr,
    output logic [7:0] irr_clr,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       spurious
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK1,
        WAIT2,
        ACK2
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(INTA_TIMEOUT);

    state_t          state;
    logic            inta_n_q;
    logic            fall;
    logic            rise;
    logic [2:0]      lvl;        // level whose vector is issued at the second INTA
    logic            spur_flag;  // current acknowledge is a spurious level-7 one
    logic [TO_W-1:0] cnt;

    logic            isr_any;
    logic [2:0]      isr_low;    // highest-priority (lowest-numbered) in-service level
    logic            req_ok;
    logic [7:0]      isr_set;
    logic [7:0]      eoi_clr;
    logic [7:0]      auto_clr;

    assign fall = inta_n_q & ~inta_n;
    assign rise = ~inta_n_q & inta_n;

    // Lowest-numbered set ISR bit. Scanning downward lets the lowest index win.
    always_comb begin
        isr_any = |isr;
        isr_low = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (isr[i]) begin
                isr_low = 3'(i);
            end
        end
    end

    // A request may interrupt only if it outranks everything already in service.
    assign req_ok = (|irr) && (!isr_any || (resolved_interrupt < isr_low));

    // The ISR set happens on the first INTA fall when the request is still valid.
    // The IRR clear uses the same one-hot mask.
    assign isr_set = (state == REQ && fall && req_ok) ? (8'b1 << resolved_interrupt) : 8'h00;

    // Non-specific EOI isolates the lowest set bit with the two's-complement trick.
    always_comb begin
        eoi_clr = 8'h00;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_clr = 8'b1 << eoi_level;
            end else begin
                eoi_clr = isr & (~isr + 8'd1);
            end
        end
    end

`ifdef AUTO_EOI_EN
    assign auto_clr = (state == ACK2 && rise && !spur_flag) ? (8'b1 << lvl) : 8'h00;
`else
    assign auto_clr = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inta_n_q  <= 1'b1;
            int_o     <= 1'b0;
            isr       <= 8'h00;
            irr_clr   <= 8'h00;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            spurious  <= 1'b0;
            lvl       <= 3'd0;
            spur_flag <= 1'b0;
            cnt       <= '0;
        end else begin
            inta_n_q <= inta_n;
            irr_clr  <= 8'h00;
            spurious <= 1'b0;
            // Clears apply first so a set on the same bit wins.
            isr      <= (isr & ~(eoi_clr | auto_clr)) | isr_set;

            case (state)
                IDLE: begin
                    // INTA activity here is ignored. Only a qualified request moves on.
                    if (req_ok) begin
                        state <= REQ;
                        int_o <= 1'b1;
                    end
                end

                REQ: begin
                    if (fall) begin
                        state <= ACK1;
                        int_o <= 1'b0;
                        if (req_ok) begin
                            lvl       <= resolved_interrupt;
                            spur_flag <= 1'b0;
                            irr_clr   <= isr_set;
                        end else begin
                            // Request vanished under the acknowledge: answer with level 7.
                            lvl       <= 3'd7;
                            spur_flag <= 1'b1;
                        end
                    end else if (!req_ok) begin
                        state <= IDLE;
                        int_o <= 1'b0;
                    end
                end

                ACK1: begin
                    if (rise) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end
                end

                WAIT2: begin
                    if (fall) begin
                        state    <= ACK2;
                        data_out <= {icw2_base, lvl};
                        data_oe  <= 1'b1;
                    end else if (cnt == TO_LIMIT) begin
                        // Abandon the acknowledge. The ISR bit stays until an EOI.
                        state     <= IDLE;
                        cnt       <= '0;
                        spur_flag <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ACK2: begin
                    if (rise) begin
                        state     <= IDLE;
                        data_oe   <= 1'b0;
                        spurious  <= spur_flag;
                        spur_flag <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
module tb_inta_sequencer;

    localparam int INTA_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irr = 8'h00;
    logic [2:0] resolved_interrupt = 3'd0;
    logic [4:0] icw2_base = 5'd0;
    logic       inta_n = 1'b1;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       int_o;
    logic [7:0] isr;
    logic [7:0] irr_clr;
    logic [7:0] data_out;
    logic       data_oe;
    logic       spurious;

    inta_sequencer #(.INTA_TIMEOUT(INTA_TIMEOUT), .TO_W(5)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .irr                (irr),
        .resolved_interrupt (resolved_interrupt),
        .icw2_base          (icw2_base),
        .inta_n             (inta_n),
        .eoi_valid          (eoi_valid),
        .eoi_specific       (eoi_specific),
        .eoi_level          (eoi_level),
        .int_o              (int_o),
        .isr                (isr),
        .irr_clr            (irr_clr),
        .data_out           (data_out),
        .data_oe            (data_oe),
        .spurious           (spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vec;
        bit         spur;
    } exp_t;

    exp_t       vec_q[$];
    logic [7:0] clr_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] isr_m = 8'h00;   // reference In-Service Register

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] low_bit(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Fully nested rule: a request must outrank every level in service.
    function automatic bit qualifies(input logic [7:0] r, input logic [7:0] s);
        return (r != 8'h00) && (s == 8'h00 || low_bit(r) < low_bit(s));
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: the bus outputs are checked against the scoreboard queues.
    logic prev_oe = 1'b0;
    bit   spur_exp = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (data_oe && !prev_oe) begin
            if (vec_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_vector: data_out %h driven, none expected", data_out);
            end else begin
                e = vec_q.pop_front();
                chk("vector", data_out, e.vec);
                spur_exp = e.spur;
            end
        end
        if (!data_oe && prev_oe) begin
            chk("spurious_pulse", 8'(spurious), 8'(spur_exp));
        end else if (spurious) begin
            checks++; errors++;
            $display("FAIL stray_spurious: spurious=1, required 0");
        end
        if (irr_clr != 8'h00) begin
            if (clr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_irr_clr: got %h required 00", irr_clr);
            end else begin
                chk("irr_clr", irr_clr, clr_q.pop_front());
            end
        end
        prev_oe = data_oe;
    end

    // Full acknowledge from request to vector, with optional spurious drop or timeout.
    task automatic do_ack(input logic [7:0] r, input logic [4:0] base,
                          input bit drop_at_fall, input bit timeout);
        logic [2:0] lv;
        bit q;
        icw2_base = base;
        irr = r;
        resolved_interrupt = low_bit(r);
        q = qualifies(r, isr_m);
        cyc(1);
        chk("int_o_assert", 8'(int_o), 8'(q));
        if (!q) begin
            // Request is blocked. An INTA here must be ignored.
            cyc(1);
            chk("int_o_blocked", 8'(int_o), 8'd0);
            inta_n = 1'b0; cyc(1); inta_n = 1'b1; cyc(2);
            chk("isr_idle_inta", isr, isr_m);
            irr = 8'h00;
            cyc(1);
            return;
        end
        inta_n = 1'b0;
        if (drop_at_fall) begin
            irr = 8'h00;
            lv = 3'd7;
        end else begin
            lv = low_bit(r);
            isr_m[lv] = 1'b1;
            clr_q.push_back(8'b1 << lv);
        end
        if (!timeout) vec_q.push_back('{{base, lv}, drop_at_fall});
        cyc(1);
        chk("isr_after_inta1", isr, isr_m);
        chk("int_o_after_inta1", 8'(int_o), 8'd0);
        irr = 8'h00;                 // IRR bit clears via irr_clr
        cyc(2); inta_n = 1'b1; cyc(3);
        if (timeout) begin
            cyc(INTA_TIMEOUT + 4);
            chk("isr_after_timeout", isr, isr_m);
            chk("int_o_after_timeout", 8'(int_o), 8'd0);
            return;
        end
        inta_n = 1'b0;
        cyc(1);
        chk("data_oe_ack2", 8'(data_oe), 8'd1);
        cyc(2); inta_n = 1'b1; cyc(1);
`ifdef AUTO_EOI_EN
        if (!drop_at_fall) isr_m[lv] = 1'b0;
`endif
        chk("isr_after_inta2", isr, isr_m);
        chk("data_oe_after_rise", 8'(data_oe), 8'd0);
        cyc(2);
    endtask

    task automatic do_eoi(input bit spec, input logic [2:0] l);
        eoi_valid = 1'b1; eoi_specific = spec; eoi_level = l;
        cyc(1);
        eoi_valid = 1'b0;
        if (spec) isr_m[l] = 1'b0;
        else      isr_m = isr_m & (isr_m - 8'd1);
        chk(spec ? "isr_spec_eoi" : "isr_nonspec_eoi", isr, isr_m);
    endtask

    // Request withdrawn before any INTA: INT must drop with no acknowledge.
    task automatic drop_before(input logic [7:0] r);
        irr = r; resolved_interrupt = low_bit(r);
        cyc(1);
        chk("int_o_pre_drop", 8'(int_o), 8'd1);
        irr = 8'h00;
        cyc(1);
        chk("int_o_post_drop", 8'(int_o), 8'd0);
        chk("isr_post_drop", isr, isr_m);
        cyc(1);
    endtask

    task automatic reset_in_ack2(input logic [7:0] r, input logic [4:0] base);
        logic [2:0] lv;
        lv = low_bit(r);
        icw2_base = base; irr = r; resolved_interrupt = lv;
        cyc(1);
        chk("int_o_assert_rst", 8'(int_o), 8'd1);
        inta_n = 1'b0;
        clr_q.push_back(8'b1 << lv);
        vec_q.push_back('{{base, lv}, 1'b0});
        cyc(1); irr = 8'h00; cyc(1); inta_n = 1'b1; cyc(2);
        inta_n = 1'b0; cyc(2);
        chk("data_oe_pre_rst", 8'(data_oe), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        isr_m = 8'h00;
        chk("data_oe_in_rst", 8'(data_oe), 8'd0);
        chk("isr_in_rst", isr, 8'h00);
        chk("int_o_in_rst", 8'(int_o), 8'd0);
        inta_n = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        #1;
        chk("rst_int_o", 8'(int_o), 8'd0);
        chk("rst_isr", isr, 8'h00);
        chk("rst_irr_clr", irr_clr, 8'h00);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_oe", 8'(data_oe), 8'd0);
        chk("rst_spurious", 8'(spurious), 8'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        do_ack(8'h04, 5'b00001, 1'b0, 1'b0);   // vector 0x0A
        do_ack(8'h20, 5'b00001, 1'b0, 1'b0);   // blocked behind level 2
        do_ack(8'h02, 5'b00001, 1'b0, 1'b0);   // nests over level 2
        do_eoi(1'b0, 3'd0);
        do_eoi(1'b1, 3'd2);
        do_eoi(1'b1, 3'd6);
        drop_before(8'h08);
        do_ack(8'h10, 5'b10101, 1'b1, 1'b0);   // spurious: vector {base,7}
        do_ack(8'h40, 5'b00110, 1'b0, 1'b1);   // timeout keeps isr[6]
        do_eoi(1'b1, 3'd6);
        do_ack(8'h08, 5'b11000, 1'b0, 1'b0);   // level 3, auto-EOI aware
        do_eoi(1'b1, 3'd3);
        reset_in_ack2(8'h01, 5'b01110);

        for (int n = 0; n < 80; n++) begin
            int op;
            logic [7:0] r;
            bit drop;
            op = $urandom_range(0, 9);
            r = 8'($urandom_range(1, 255));
            if (op <= 4) begin
                drop = ($urandom_range(0, 7) == 0);
                do_ack(r, 5'($urandom), drop, !drop && ($urandom_range(0, 9) == 0));
            end else if (op <= 6) begin
                do_eoi(1'b0, 3'd0);
            end else if (op <= 8) begin
                do_eoi(1'b1, 3'($urandom_range(0, 7)));
            end else if (qualifies(r, isr_m)) begin
                drop_before(r);
            end else begin
                do_eoi(1'b0, 3'd0);
            end
        end

        cyc(3);
        chk("vec_q_drained", 8'(vec_q.size()), 8'd0);
        chk("clr_q_drained", 8'(clr_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Owns the CPU side of the 8259A interrupt path.
- Takes the priority resolver's winning level and the raw IRR, and maintains the In-Service Register (ISR) under fully-nested priority.
- Drives INT to the CPU, runs the two-pulse 8086 INTA acknowledge, and places the vector byte on the data bus.
- Handles EOI commands from the command decoder; the priority resolver sits upstream of this block.

Parameters:
- INTA_TIMEOUT, 16, cycles allowed between first-INTA rising edge and second-INTA falling edge before abort.
- TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > INTA_TIMEOUT.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- irr  input  8  current Interrupt Request Register, already masked.
- resolved_interrupt  input  3  highest-priority requesting level from the priority resolver.
- icw2_base  input  5  vector bits T7..T3 from ICW2.
- inta_n  input  1  CPU acknowledge, active low, synchronous to clk.
- eoi_valid  input  1  one-cycle EOI command strobe.
- eoi_specific  input  1  1 = specific EOI, 0 = non-specific.
- eoi_level  input  3  level for a specific EOI.
- int_o  output  1  interrupt request to CPU.
- isr  output  8  In-Service Register.
- irr_clr  output  8  one-cycle one-hot clear to IRR on first INTA.
- data_out  output  8  vector byte.
- data_oe  output  1  data bus drive enable.
- spurious  output  1  one-cycle pulse when a level-7 spurious vector is issued.

Behaviour:
- Reset (async, rst_n low): int_o=0, isr=0, irr_clr=0, data_out=0, data_oe=0, spurious=0, FSM=IDLE, timeout counter=0.
- Reset applies immediately mid-sequence; data_oe drops in the same instant.
- Edge detect: inta_n_q is inta_n registered.
  - fall = inta_n_q & ~inta_n.
  - rise = ~inta_n_q & inta_n.
- Qualify (combinational): req_ok = (|irr) and (isr==0 or resolved_interrupt < index of lowest-numbered set bit of isr). Lower level number = higher priority.
- FSM states IDLE, REQ, ACK1, WAIT2, ACK2.
  - IDLE: req_ok -> REQ; int_o=1 from the next cycle (1-cycle latency).
  - REQ: if req_ok drops before any INTA, int_o=0 and -> IDLE. On fall, -> ACK1:
    - if req_ok: isr[resolved_interrupt] set, irr_clr one-hot pulsed one cycle, level latched as lvl.
    - else: lvl=7, spurious flag latched, isr unchanged, no irr_clr.
  - ACK1: int_o=0. On rise -> WAIT2; counter cleared.
  - WAIT2: counter increments each cycle. On fall -> ACK2. If counter reaches INTA_TIMEOUT -> IDLE; isr keeps its bit; no vector is driven.
  - ACK2: data_out={icw2_base,lvl}, data_oe=1 from the cycle after fall until the cycle after rise. spurious pulses one cycle at rise if flagged. On rise -> IDLE.
- int_o re-asserts only after returning to IDLE and re-qualifying. The minimum gap between the end of an acknowledge and the next INT is 1 cycle.
- EOI (evaluated in any state):
  - Non-specific: clears the lowest-numbered set isr bit. No effect if isr==0.
  - Specific: clears isr[eoi_level]. No effect if that bit is already 0.
  - If an EOI and an ISR set happen in the same cycle on different bits, both apply. On the same bit, the set wins.
- An INTA fall seen in IDLE or WAIT2-timeout recovery is ignored. No ISR change, no vector driven.
- irr changes during ACK1/WAIT2/ACK2 do not alter lvl.

Optional Feature:
- Macro AUTO_EOI_EN.
- Defined: at the ACK2 rise, isr[lvl] clears automatically (Automatic EOI mode).
  - Spurious cycles are unaffected.
  - eoi_valid strobes are still honoured.
- Undefined: isr bits clear only via eoi_valid.

Test Plan:
- Basic acknowledge:
  - Stimulus: icw2_base=5'b00001, irr=8'h04, resolved_interrupt=2.
  - Required: int_o=1 one cycle later.
  - INTA#1 fall: isr=8'h04, irr_clr=8'h04 for one cycle.
  - INTA#2: data_out=8'h0A with data_oe=1; int_o=0 after INTA#1.
- Nesting:
  - Stimulus: with isr=8'h04, irr=8'h20 (level 5).
  - Required: int_o stays 0.
  - Then irr=8'h02 (level 1): int_o=1; after acknowledge, isr=8'h06.
- EOI:
  - Non-specific EOI with isr=8'h06 -> isr=8'h04.
  - Specific EOI level 2 -> isr=8'h00.
  - Specific EOI level 6 on isr=0 -> no change.
- Spurious:
  - Stimulus: irr drops to 0 after int_o=1 but before INTA#1.
  - Required: INT deasserts and FSM -> IDLE.
  - Repeat with the drop between cycle of fall: data_out={base,3'd7}, spurious pulse, isr unchanged, irr_clr=0.
- Timeout and reset:
  - No second INTA within 16 cycles -> IDLE with data_oe never asserted, isr bit retained.
  - rst_n low during ACK2 -> data_oe, isr, int_o all 0 immediately.
- AUTO_EOI_EN build:
  - Stimulus: a level-3 acknowledge.
  - Required: isr[3]=1 after INTA#1 and 0 in the cycle after the INTA#2 rise.
  - Without the macro: isr[3] remains 1.
